// File: rtl/gpio_cmd_pkg.sv
// rtl/gpio_cmd_pkg.sv - opcodes, state codes and status-word layout shared by the GPIO command path
package gpio_cmd_pkg;

   localparam logic [2:0] OP_KNL    = 3'b000;
   localparam logic [2:0] OP_SIZE   = 3'b001;
   localparam logic [2:0] OP_IMG    = 3'b010;
   localparam logic [2:0] OP_REQ    = 3'b011;
   localparam logic [2:0] OP_GO     = 3'b100;
   localparam logic [2:0] OP_ABORT  = 3'b101;
   localparam logic [2:0] OP_CLRERR = 3'b110;
   localparam logic [2:0] OP_ILL    = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   // o_GPIOdata layout: {state[2:0], err, knl_done, run, mcu_data[25:0]}
   localparam int GD_STATE_LSB = 29;
   localparam int GD_ERR_BIT   = 28;
   localparam int GD_KDONE_BIT = 27;
   localparam int GD_RUN_BIT   = 26;
   localparam int GD_DATA_W    = 26;

endpackage

// File: rtl/gpio_cmd_ctrl_valid_edge_det.sv
// rtl/gpio_cmd_ctrl_valid_edge_det.sv - registered rising-edge detector for the GPIO valid line
module valid_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic valid,
   output logic rise
);

   logic hist;
   logic armed;

   // armed stays low until valid is seen low, so a level held across reset is not a command
   always_ff @(posedge clk) begin
      if (rst) begin
         hist  <= 1'b0;
         armed <= 1'b0;
      end else begin
         hist <= valid;
         if (!valid)
            armed <= 1'b1;
      end
   end

   assign rise = valid & ~hist & armed;

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// rtl/gpio_cmd_ctrl.sv - GPIO opcode decoder, frame sequencer and control registers for the conv datapath
module gpio_cmd_ctrl
   import gpio_cmd_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int PIX_W     = 8,
   parameter int IMGLEN_W  = 10,
   parameter int KNL_WORDS = 3,
   parameter int RESULT_W  = 13,
   localparam int KIDX_W   = $clog2(KNL_WORDS)
) (
   input  logic                i_CLK,
   input  logic                i_rst,
   input  logic [DATA_W-1:0]   i_GPIOdata,
   input  logic [2:0]          i_GPIOctrl,
   input  logic                i_GPIOvalid,
   input  logic [RESULT_W-1:0] i_MCUdata,
   input  logic                i_EOP_from_FSM,
   output logic [31:0]         o_GPIOdata,
   output logic [DATA_W-1:0]   o_KNLdata,
   output logic [KIDX_W-1:0]   o_knl_idx,
   output logic                o_valid_to_CONV,
   output logic [PIX_W-1:0]    o_MCUdata,
   output logic                o_valid_to_FSM,
   output logic [IMGLEN_W-1:0] o_imgLength,
   output logic                o_load,
   output logic                o_run,
   output logic                o_KNorIMG,
   output logic                o_EOP_to_MCU,
   output logic                o_err
);

   localparam logic [KIDX_W-1:0] KLAST = KIDX_W'(KNL_WORDS - 1);

   logic              cmd;
   state_t            state;
   state_t            state_nxt;
   logic [KIDX_W-1:0] kcnt;
   logic              knl_done;
   logic              in_cfg;
   logic              go_ok;
   logic [31:0]       status;

   valid_edge_det u_edge (
      .clk   (i_CLK),
      .rst   (i_rst),
      .valid (i_GPIOvalid),
      .rise  (cmd)
   );

   assign in_cfg = (state == ST_IDLE) || (state == ST_LOAD);
   assign go_ok  = knl_done && (o_imgLength != '0);

   always_ff @(posedge i_CLK) begin
      if (i_rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // ABORT is checked first so it beats a coincident end-of-processing
   always_comb begin
      state_nxt = state;
      if (cmd && i_GPIOctrl == OP_ABORT) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_LOAD: begin
               if (cmd && i_GPIOctrl == OP_GO && go_ok)
                  state_nxt = ST_RUN;
               else if (cmd && i_GPIOctrl == OP_IMG)
                  state_nxt = ST_LOAD;
            end
            ST_RUN:  if (i_EOP_from_FSM) state_nxt = ST_OUT;
            ST_OUT:  if (cmd && i_GPIOctrl == OP_IMG) state_nxt = ST_LOAD;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      status = '0;
      status[GD_STATE_LSB +: 2] = state;
      status[GD_ERR_BIT]        = o_err;
      status[GD_KDONE_BIT]      = knl_done;
      status[GD_RUN_BIT]        = o_run;
      status[GD_DATA_W-1:0]     = GD_DATA_W'(i_MCUdata);
   end

   always_ff @(posedge i_CLK) begin
      if (i_rst) begin
         o_GPIOdata      <= '0;
         o_KNLdata       <= '0;
         o_knl_idx       <= '0;
         o_valid_to_CONV <= 1'b0;
         o_MCUdata       <= '0;
         o_valid_to_FSM  <= 1'b0;
         o_imgLength     <= '0;
         o_load          <= 1'b0;
         o_run           <= 1'b0;
         o_KNorIMG       <= 1'b0;
         o_EOP_to_MCU    <= 1'b0;
         o_err           <= 1'b0;
         kcnt            <= '0;
         knl_done        <= 1'b0;
      end else begin
         o_valid_to_CONV <= 1'b0;
         o_valid_to_FSM  <= 1'b0;
         o_load          <= (state_nxt == ST_LOAD);
         o_run           <= (state_nxt == ST_RUN);
         o_KNorIMG       <= (state_nxt == ST_RUN);
         o_GPIOdata      <= status;
         if (state == ST_RUN && i_EOP_from_FSM)
            o_EOP_to_MCU <= 1'b1;
         if (cmd) begin
            if (i_GPIOctrl == OP_ABORT) begin
               o_EOP_to_MCU <= 1'b0;
               kcnt         <= '0;
            end else if (state != ST_RUN) begin
               case (i_GPIOctrl)
                  OP_KNL: begin
                     if (in_cfg) begin
                        o_KNLdata       <= i_GPIOdata;
                        o_knl_idx       <= kcnt;
                        o_valid_to_CONV <= 1'b1;
                        if (kcnt == '0)
                           knl_done <= 1'b0;
                        if (kcnt == KLAST) begin
                           kcnt     <= '0;
                           knl_done <= 1'b1;
                        end else begin
                           kcnt <= kcnt + 1'b1;
                        end
                     end else begin
                        o_err <= 1'b1;
                     end
                  end
                  OP_SIZE: begin
                     if (in_cfg)
                        o_imgLength <= i_GPIOdata[IMGLEN_W-1:0];
                     else
                        o_err <= 1'b1;
                  end
                  OP_IMG: begin
                     o_MCUdata      <= i_GPIOdata[PIX_W-1:0];
                     o_valid_to_FSM <= 1'b1;
                     if (state != ST_LOAD)
                        o_EOP_to_MCU <= 1'b0;
                  end
                  OP_REQ: begin
                     if (state == ST_OUT)
                        o_valid_to_FSM <= 1'b1;
                     else
                        o_err <= 1'b1;
                  end
                  OP_GO:     if (in_cfg && !go_ok) o_err <= 1'b1;
                  OP_ABORT:  ;
                  OP_CLRERR: o_err <= 1'b0;
                  OP_ILL:    o_err <= 1'b1;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// tb/tb_gpio_cmd_ctrl.sv - directed self-checking bench for gpio_cmd_ctrl
module tb_gpio_cmd_ctrl;
   import gpio_cmd_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] gdata;
   logic [2:0]  gctrl;
   logic        gvalid;
   logic [12:0] mcu_in;
   logic        eop;
   logic [31:0] gpio_out;
   logic [23:0] knl_data;
   logic [1:0]  knl_idx;
   logic        v_conv;
   logic [7:0]  mcu_data;
   logic        v_fsm;
   logic [9:0]  img_len;
   logic        load, run, knorimg, eop_mcu, err;

   int total = 0;
   int bad   = 0;
   int conv_n = 0;
   int fsm_n  = 0;

   always #5 clk = ~clk;

   gpio_cmd_ctrl dut (
      .i_CLK           (clk),
      .i_rst           (rst),
      .i_GPIOdata      (gdata),
      .i_GPIOctrl      (gctrl),
      .i_GPIOvalid     (gvalid),
      .i_MCUdata       (mcu_in),
      .i_EOP_from_FSM  (eop),
      .o_GPIOdata      (gpio_out),
      .o_KNLdata       (knl_data),
      .o_knl_idx       (knl_idx),
      .o_valid_to_CONV (v_conv),
      .o_MCUdata       (mcu_data),
      .o_valid_to_FSM  (v_fsm),
      .o_imgLength     (img_len),
      .o_load          (load),
      .o_run           (run),
      .o_KNorIMG       (knorimg),
      .o_EOP_to_MCU    (eop_mcu),
      .o_err           (err)
   );

   // strobe counters sampled just after each active edge
   always @(posedge clk) begin
      #1;
      if (v_conv) conv_n++;
      if (v_fsm)  fsm_n++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [23:0] d, input int hold);
      @(negedge clk);
      gctrl  = op;
      gdata  = d;
      gvalid = 1'b1;
      repeat (hold) @(negedge clk);
      gvalid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; gvalid = 1'b1; gctrl = OP_KNL; gdata = 24'h010203; eop = 1'b0; mcu_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_gpio", gpio_out, 32'h0);
      chk("rst_flags", {load, run, knorimg, eop_mcu, err, v_conv, v_fsm}, 32'h0);
      chk("rst_knl", knl_data, 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("held_valid_no_cmd", conv_n, 0);
      chk("held_valid_knl", knl_data, 32'h0);
      gvalid = 1'b0; @(negedge clk);
      gvalid = 1'b1; @(negedge clk);
      gvalid = 1'b0; @(negedge clk);
      chk("knl0_pulse", conv_n, 1);
      chk("knl0_data", knl_data, 32'h010203);
      chk("knl0_idx", knl_idx, 0);
      send(OP_KNL, 24'h040506, 1);
      chk("knl1_idx", knl_idx, 1);
      send(OP_KNL, 24'h070809, 1);
      chk("knl2_idx", knl_idx, 2);
      chk("knl_pulses", conv_n, 3);
      chk("knl_done", gpio_out[27], 1);

      send(OP_GO, 24'h0, 1);
      chk("go_len0_err", err, 1);
      chk("go_len0_state", gpio_out[31:29], 0);
      send(OP_CLRERR, 24'h0, 1);
      chk("clrerr", err, 0);
      send(OP_KNL, 24'h111111, 1);
      chk("knl_restart_done", gpio_out[27], 0);
      send(OP_SIZE, 24'h00000A, 1);
      chk("size", img_len, 10);
      send(OP_GO, 24'h0, 1);
      chk("go_nokernel_err", err, 1);
      chk("go_nokernel_run", run, 0);
      send(OP_CLRERR, 24'h0, 1);
      send(OP_KNL, 24'h222222, 1);
      send(OP_KNL, 24'h333333, 1);
      chk("knl_done2", gpio_out[27], 1);

      send(OP_IMG, 24'h000055, 1);
      chk("img55_load", load, 1);
      chk("img55_data", mcu_data, 8'h55);
      chk("img55_pulse", fsm_n, 1);
      send(OP_IMG, 24'h0000AA, 5);
      chk("imgAA_data", mcu_data, 8'hAA);
      chk("imgAA_single_pulse", fsm_n, 2);
      send(OP_REQ, 24'h0, 1);
      chk("req_in_load_err", err, 1);
      send(OP_CLRERR, 24'h0, 1);

      send(OP_GO, 24'h0, 1);
      chk("go_run_flags", {load, run, knorimg}, 3'b011);
      chk("go_state", gpio_out[31:29], 2);
      send(OP_IMG, 24'h000099, 1);
      chk("run_ignore_img", {fsm_n[7:0], mcu_data}, {8'd2, 8'hAA});
      chk("run_ignore_err", err, 0);

      @(negedge clk); eop = 1'b1;
      @(negedge clk); eop = 1'b0;
      chk("eop_latency", {eop_mcu, run, knorimg}, 3'b100);
      send(OP_REQ, 24'h0, 1);
      send(OP_REQ, 24'h0, 1);
      chk("req_pulses", fsm_n, 4);
      @(negedge clk); mcu_in = 13'h1ABC;
      @(negedge clk);
      chk("readback_data", gpio_out[12:0], 13'h1ABC);
      chk("readback_state", gpio_out[31:29], 3);
      send(OP_KNL, 24'h555555, 1);
      chk("knl_in_out_err", err, 1);
      chk("knl_in_out_keep", knl_data, 32'h333333);
      send(OP_CLRERR, 24'h0, 1);
      send(OP_IMG, 24'h000077, 1);
      chk("out_img_reload", {load, eop_mcu}, 2'b10);
      chk("out_img_data", mcu_data, 8'h77);

      send(OP_GO, 24'h0, 1);
      chk("go_again", run, 1);
      @(negedge clk); gctrl = OP_ABORT; gvalid = 1'b1; eop = 1'b1;
      @(negedge clk); eop = 1'b0; gvalid = 1'b0;
      chk("abort_eop_flags", {load, run, knorimg, eop_mcu}, 4'b0000);
      @(negedge clk);
      chk("abort_state", gpio_out[31:29], 0);
      chk("abort_keep_len", img_len, 10);
      chk("abort_keep_knl", knl_data, 32'h333333);
      send(OP_KNL, 24'h444444, 1);
      chk("abort_kcnt_clr", knl_idx, 0);

      send(OP_IMG, 24'h000066, 1);
      chk("pre_rst_pulses", fsm_n, 6);
      @(negedge clk); gctrl = OP_IMG; gdata = 24'h000012; gvalid = 1'b1; rst = 1'b1;
      @(negedge clk);
      chk("midrst_drop", fsm_n, 6);
      chk("midrst_outs", {load, mcu_data, gpio_out[31:26]}, 32'h0);
      rst = 1'b0; gvalid = 1'b0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
